data_mem_responder: RTL and testbench

// - Responder end of the processor data-memory port: accepts CEN/WEN/OEN/A/Data2Mem strobes and returns ReadDataMem.
// - Holds 2**ADDR_W x DATA_W words. Zero-fills all storage after reset. Counts completed accesses.
// - Replaces the behavioural testbench memory so processor benches run against synthesizable RTL.

---
 rtl/data_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Synthesizable responder for the processor data-memory port. It holds
// 2**ADDR_W words of DATA_W bits and zero-fills them one word per cycle after
// reset. Once the fill is done it answers CEN/WEN/OEN strobes and counts the
// reads and writes it completes.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   CEN          chip enable, active low
//   WEN          write enable, active low (only meaningful with CEN=0)
//   OEN          output enable, active low (read when CEN=0, WEN=1)
//   A            word address
//   Data2Mem     write data
//   ReadDataMem  read data (same cycle if READ_REG=0, next cycle if READ_REG=1)
//   ready        1 once the zero-fill has finished
//   rd_count     completed reads, saturating
//   wr_count     completed writes, saturating
//   perr         sticky parity error (only when DMEM_PARITY_EN is defined)
//
// Build option
//   DMEM_PARITY_EN  adds an even-parity bit to every word and the perr output.
//
// state  | meaning
// CLEAR  | zero-filling mem[clr_ptr], strobes ignored, ready=0
// SERVE  | fill finished, strobes decoded, ready=1
module data_mem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 7,
    parameter int READ_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
`ifdef DMEM_PARITY_EN
    ,
    output logic              perr
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              ready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready     <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_SERVE;
                    ready_d = 1'b1;
                end
            end
            ST_SERVE: begin
                state_d = ST_SERVE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Access decode. Gated by rst so a strobe in the reset cycle never lands.
    logic serving;
    logic do_wr;
    logic do_rd;

    assign serving = (state_q == ST_SERVE) && !rst;
    assign do_wr   = serving && !CEN && !WEN;
    assign do_rd   = serving && !CEN && WEN && !OEN;

    // Single write port shared between the zero-fill and normal writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = do_wr;
        mem_waddr = A;
        mem_wdata = Data2Mem;
        if ((state_q == ST_CLEAR) && !rst) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_q;

    assign rd_word = mem[A];

    // rd_q is the registered read data in READ_REG=1 and the "last value"
    // the output holds between reads in READ_REG=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (do_rd) begin
            rd_q <= rd_word;
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            assign ReadDataMem = rd_q;
        end else begin : g_rd_comb
            assign ReadDataMem = do_rd ? rd_word : rd_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (do_rd && (rd_count != {CNT_W{1'b1}})) begin
                rd_count <= rd_count + 1'b1;
            end
            if (do_wr && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

`ifdef DMEM_PARITY_EN
    // Even parity: stored bit equals the XOR of the data, so zero-filled
    // words carry parity 0 automatically.
    logic mem_par [DEPTH];
    logic par_bad;
    logic perr_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_par[mem_waddr] <= ^mem_wdata;
        end
    end

    assign par_bad = do_rd && ((^rd_word) != mem_par[A]);

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (par_bad) begin
            perr_q <= 1'b1;
        end
    end

    // perr must track the cycle in which ReadDataMem becomes valid.
    generate
        if (READ_REG != 0) begin : g_perr_reg
            assign perr = perr_q;
        end else begin : g_perr_comb
            assign perr = perr_q | par_bad;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wen;
    logic        oen;
    logic [6:0]  a;
    logic [31:0] d;

    logic [31:0] rdm0, rdm1;
    logic        ready0, ready1;
    logic [15:0] rc0, wc0;
    logic [3:0]  rc1, wc1;
`ifdef DMEM_PARITY_EN
    logic        perr0, perr1;
`endif

    // Combinational-read instance with full-width counters.
    data_mem_responder #(.DATA_W(32), .ADDR_W(7), .READ_REG(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a),
        .Data2Mem(d), .ReadDataMem(rdm0), .ready(ready0),
        .rd_count(rc0), .wr_count(wc0)
`ifdef DMEM_PARITY_EN
        , .perr(perr0)
`endif
    );

    // Registered-read instance with narrow counters so saturation is reachable.
    data_mem_responder #(.DATA_W(32), .ADDR_W(7), .READ_REG(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a),
        .Data2Mem(d), .ReadDataMem(rdm1), .ready(ready1),
        .rd_count(rc1), .wr_count(wc1)
`ifdef DMEM_PARITY_EN
        , .perr(perr1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [31:0] mmem [128];
    int          n_rd;
    int          n_wr;
    logic [31:0] hold0;
    logic [31:0] hold1;
    logic [31:0] sb [$];

    function automatic logic [15:0] exp16(input int n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    function automatic logic [3:0] exp4(input int n);
        return (n > 15) ? 4'hF : n[3:0];
    endfunction

    task automatic apply_reset(input bit rd_strobe, input logic [6:0] ra);
        @(negedge clk);
        rst = 1'b1;
        if (rd_strobe) begin
            cen = 1'b0; wen = 1'b1; oen = 1'b0; a = ra;
        end else begin
            cen = 1'b1; wen = 1'b1; oen = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            failures++; $display("FAIL reset_ready got %b/%b want 0/0", ready0, ready1);
        end
        checks++;
        if (rdm0 !== 32'h0 || rdm1 !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got %h/%h want 0/0", rdm0, rdm1);
        end
        checks++;
        if (rc0 !== 16'h0 || wc0 !== 16'h0 || rc1 !== 4'h0 || wc1 !== 4'h0) begin
            failures++; $display("FAIL reset_counts got %0d/%0d/%0d/%0d want 0", rc0, wc0, rc1, wc1);
        end
        @(negedge clk);
        rst = 1'b0; cen = 1'b1; wen = 1'b1; oen = 1'b1;
        n_rd = 0; n_wr = 0; hold0 = '0; hold1 = '0;
        sb.delete();
    endtask

    task automatic wait_ready(input bit strobe);
        int cnt;
        if (strobe) begin
            cen = 1'b0; wen = 1'b0; oen = 1'b1; a = 7'd3; d = 32'h1234;
        end
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (ready0 !== 1'b1 && cnt < 300);
        cen = 1'b1; wen = 1'b1; oen = 1'b1;
        checks++;
        if (cnt != 128 || ready1 !== 1'b1) begin
            failures++; $display("FAIL clear_time got %0d cycles (ready1=%b) want 128", cnt, ready1);
        end
        checks++;
        if (wc0 !== 16'h0 || rc0 !== 16'h0 || rdm0 !== 32'h0 || rdm1 !== 32'h0) begin
            failures++; $display("FAIL clear_quiet got wc=%0d rc=%0d rd=%h/%h want 0", wc0, rc0, rdm0, rdm1);
        end
        for (int i = 0; i < 128; i++) mmem[i] = '0;
    endtask

    task automatic wait_cycles_not_ready(input int n);
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (ready0 !== 1'b0) begin
            failures++; $display("FAIL midclear_ready got %b want 0", ready0);
        end
    endtask

    task automatic do_op(input logic cen_v, input logic wen_v, input logic oen_v,
                         input logic [6:0] a_v, input logic [31:0] d_v);
        bit          rd;
        bit          wr;
        logic [31:0] exp0;
        logic [31:0] exp1;
        @(negedge clk);
        cen = cen_v; wen = wen_v; oen = oen_v; a = a_v; d = d_v;
        rd = !cen_v && wen_v && !oen_v;
        wr = !cen_v && !wen_v;
        if (rd) sb.push_back(mmem[a_v]);
        #1;
        exp0 = rd ? mmem[a_v] : hold0;
        checks++;
        if (rdm0 !== exp0) begin
            failures++; $display("FAIL rdata_comb a=%0d got %h want %h", a_v, rdm0, exp0);
        end
        @(posedge clk); #1;
        if (wr) begin mmem[a_v] = d_v; n_wr++; end
        if (rd) begin
            n_rd++;
            hold0 = exp0;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty a=%0d got %h want queued entry", a_v, rdm1);
            end else begin
                exp1 = sb.pop_front();
                hold1 = exp1;
            end
        end
        checks++;
        if (rdm1 !== hold1) begin
            failures++; $display("FAIL rdata_reg a=%0d got %h want %h", a_v, rdm1, hold1);
        end
        checks++;
        if (rc0 !== exp16(n_rd) || wc0 !== exp16(n_wr)) begin
            failures++; $display("FAIL counts16 got rd=%0d wr=%0d want rd=%0d wr=%0d", rc0, wc0, exp16(n_rd), exp16(n_wr));
        end
        checks++;
        if (rc1 !== exp4(n_rd) || wc1 !== exp4(n_wr)) begin
            failures++; $display("FAIL counts4 got rd=%0d wr=%0d want rd=%0d wr=%0d", rc1, wc1, exp4(n_rd), exp4(n_wr));
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b0, 7'd0);
        wait_ready(1'b0);
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < 128; i++) do_op(1'b0, 1'b1, 1'b0, 7'(i), 32'h0);
    endtask

    task automatic test_write_read();
        apply_reset(1'b0, 7'd0);
        wait_ready(1'b0);
        do_op(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
        do_op(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    endtask

    task automatic test_non_access();
        do_op(1'b0, 1'b1, 1'b1, 7'd5, 32'h11111111);
        do_op(1'b1, 1'b0, 1'b0, 7'd5, 32'h0BAD0BAD);
        do_op(1'b1, 1'b1, 1'b1, 7'd6, 32'h22222222);
        do_op(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    endtask

    task automatic test_clear_strobes();
        apply_reset(1'b0, 7'd0);
        wait_ready(1'b1);
        do_op(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 10; i < 20; i++) do_op(1'b0, 1'b0, 1'b1, 7'(i), $urandom);
        do_op(1'b0, 1'b0, 1'b0, 7'd20, 32'hCAFEF00D);
        for (int i = 10; i < 21; i++) do_op(1'b0, 1'b1, 1'b0, 7'(i), 32'h0);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 1'b0, 1'b1, 7'd30, $urandom);
            do_op(1'b0, 1'b1, 1'b0, 7'd30, 32'h0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            do_op(s[2], s[1], s[0], 7'($urandom_range(0, 15)), $urandom);
        end
    endtask

    task automatic test_reset_mid();
        do_op(1'b0, 1'b0, 1'b1, 7'd7, 32'hA5A5A5A5);
        do_op(1'b0, 1'b1, 1'b0, 7'd7, 32'h0);
        // Read strobe held through the reset cycle must not surface.
        apply_reset(1'b1, 7'd7);
        wait_cycles_not_ready(40);
        apply_reset(1'b0, 7'd0);
        wait_ready(1'b0);
        do_op(1'b0, 1'b1, 1'b0, 7'd7, 32'h0);
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        do_op(1'b0, 1'b0, 1'b1, 7'd9, 32'h0F0F1234);
        do_op(1'b0, 1'b1, 1'b0, 7'd9, 32'h0);
        checks++;
        if (perr0 !== 1'b0 || perr1 !== 1'b0) begin
            failures++; $display("FAIL perr_clean got %b/%b want 0/0", perr0, perr1);
        end
        @(negedge clk);
        dut0.mem[9][0] = ~dut0.mem[9][0];
        dut1.mem[9][0] = ~dut1.mem[9][0];
        mmem[9][0] = ~mmem[9][0];
        @(negedge clk);
        cen = 1'b0; wen = 1'b1; oen = 1'b0; a = 7'd9;
        #1;
        checks++;
        if (perr0 !== 1'b1) begin
            failures++; $display("FAIL perr_comb got %b want 1", perr0);
        end
        @(posedge clk); #1;
        cen = 1'b1;
        checks++;
        if (perr1 !== 1'b1) begin
            failures++; $display("FAIL perr_reg got %b want 1", perr1);
        end
        n_rd++; hold0 = mmem[9]; hold1 = mmem[9];
        repeat (5) do_op(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
        checks++;
        if (perr0 !== 1'b1 || perr1 !== 1'b1) begin
            failures++; $display("FAIL perr_sticky got %b/%b want 1/1", perr0, perr1);
        end
        apply_reset(1'b0, 7'd0);
        checks++;
        if (perr0 !== 1'b0 || perr1 !== 1'b0) begin
            failures++; $display("FAIL perr_reset got %b/%b want 0/0", perr0, perr1);
        end
        wait_ready(1'b0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; cen = 1'b1; wen = 1'b1; oen = 1'b1; a = '0; d = '0;
        n_rd = 0; n_wr = 0; hold0 = '0; hold1 = '0;
        for (int i = 0; i < 128; i++) mmem[i] = '0;
        test_reset();
        test_clear_readback();
        test_write_read();
        test_non_access();
        test_clear_strobes();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
